// File: rtl/cp0_int_pkg.sv
// CP0 shared constants: register numbers, exception codes, SR/Cause field positions.
package cp0_pkg;
   localparam logic [31:0] PRID_DEFAULT = 32'h0000_2019;
   localparam int          HW_INT_W     = 6;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int IM_LO    = 10;
   localparam int IM_HI    = 15;
   localparam int CAUSE_BD = 31;
   localparam int EXC_LO   = 2;
   localparam int EXC_HI   = 6;

   typedef enum logic {
      NORMAL  = 1'b0,
      HANDLER = 1'b1
   } state_t;
endpackage

// File: rtl/cp0_int_if.sv
// Pipeline <-> CP0 bundle: mfc0/mtc0 access, victim info, IRQ lines, redirect.
interface cp0_int_if;
   import cp0_pkg::*;

   logic [4:0]          rd_addr;
   logic [4:0]          wr_addr;
   logic [31:0]         wdata;
   logic                we;
   logic [31:0]         pc;
   logic                bd;
   logic [4:0]          exc_code;
   logic [HW_INT_W-1:0] hw_int;
   logic                eret;
   logic [31:0]         rdata;
   logic                int_req;
   logic [31:0]         epc;

   modport master (
      output rd_addr, wr_addr, wdata, we, pc, bd,
      output exc_code, hw_int, eret,
      input  rdata, int_req, epc
   );

   modport slave (
      input  rd_addr, wr_addr, wdata, we, pc, bd,
      input  exc_code, hw_int, eret,
      output rdata, int_req, epc
   );
endinterface

// File: rtl/cp0_int_arb.sv
// Interrupt vs. exception arbitration; a pending IRQ beats a sync exception.
module cp0_int_arb
   import cp0_pkg::*;
(
   input  logic [HW_INT_W-1:0] hw_int_i,
   input  logic [HW_INT_W-1:0] im_i,
   input  logic                ie_i,
   input  logic                exl_i,
   input  logic [4:0]          exc_code_i,
   output logic                irq_hit_o,
   output logic                exc_hit_o,
   output logic                int_req_o,
   output logic [4:0]          exc_code_o
);
   assign irq_hit_o  = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
   assign exc_hit_o  = (exc_code_i != EXC_INT) & ~exl_i;
   assign int_req_o  = irq_hit_o | exc_hit_o;
   assign exc_code_o = irq_hit_o ? EXC_INT : exc_code_i;
endmodule

// File: rtl/cp0_int.sv
// CP0 SR/Cause/EPC/PRId registers with a NORMAL/HANDLER state on SR.EXL.
module cp0_int
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID = PRID_DEFAULT
) (
   input  logic      clk,
   input  logic      reset,
   cp0_int_if.slave  bus
);
   state_t              state_q, state_d;
   logic [HW_INT_W-1:0] im_q, im_d;
   logic                ie_q, ie_d;
   logic                bd_q, bd_d;
   logic [HW_INT_W-1:0] ip_q, ip_d;
   logic [4:0]          exc_q, exc_d;
   logic [31:2]         epc_q, epc_d;

   logic        exl;
   logic        irq_hit, exc_hit, int_req;
   logic [4:0]  exc_nxt;
   logic [31:0] vpc;
   logic [31:0] sr_w, cause_w, epc_w;

   assign exl = (state_q == HANDLER);

   cp0_int_arb u_arb (
      .hw_int_i   (bus.hw_int),
      .im_i       (im_q),
      .ie_i       (ie_q),
      .exl_i      (exl),
      .exc_code_i (bus.exc_code),
      .irq_hit_o  (irq_hit),
      .exc_hit_o  (exc_hit),
      .int_req_o  (int_req),
      .exc_code_o (exc_nxt)
   );

   assign vpc     = bus.bd ? bus.pc - 32'd4 : bus.pc;
   assign sr_w    = {16'b0, im_q, 8'b0, exl, ie_q};
   assign cause_w = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
   assign epc_w   = {epc_q, 2'b00};

   assign bus.int_req = int_req;
   assign bus.epc     = epc_w;

   always_comb begin
      bus.rdata = 32'b0;
      unique case (bus.rd_addr)
         REG_SR:    bus.rdata = sr_w;
         REG_CAUSE: bus.rdata = cause_w;
         REG_EPC:   bus.rdata = epc_w;
         REG_PRID:  bus.rdata = PRID;
         default:   bus.rdata = 32'b0;
      endcase
   end

   // A taken exception drops any same-cycle mtc0; the victim re-executes.
   always_comb begin
      state_d = state_q;
      im_d    = im_q;
      ie_d    = ie_q;
      bd_d    = bd_q;
      exc_d   = exc_q;
      epc_d   = epc_q;
      ip_d    = bus.hw_int;
      if (int_req) begin
         state_d = HANDLER;
         bd_d    = bus.bd;
         exc_d   = exc_nxt;
         epc_d   = vpc[31:2];
      end else begin
         if (bus.we && bus.wr_addr == REG_SR) begin
            im_d    = bus.wdata[IM_HI:IM_LO];
            ie_d    = bus.wdata[SR_IE];
            state_d = bus.wdata[SR_EXL] ? HANDLER : NORMAL;
         end
         if (bus.we && bus.wr_addr == REG_EPC)
            epc_d = bus.wdata[31:2];
         if (bus.eret)
            state_d = NORMAL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= NORMAL;
         im_q    <= '0;
         ie_q    <= 1'b0;
         bd_q    <= 1'b0;
         ip_q    <= '0;
         exc_q   <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         im_q    <= im_d;
         ie_q    <= ie_d;
         bd_q    <= bd_d;
         ip_q    <= ip_d;
         exc_q   <= exc_d;
         epc_q   <= epc_d;
      end
   end

   logic unused;
   assign unused = ^{vpc[1:0], bus.wdata[9:2], bus.wdata[31:16],
                     exc_hit, irq_hit};
endmodule

// File: tb/tb_cp0_int.sv
// Scoreboard bench for cp0_int: expectations queued at drive, checked at sample.
module tb_cp0_int;
   import cp0_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cp0_int_if bus ();

   cp0_int dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef enum {K_INT, K_RD, K_EPC} kind_t;
   typedef struct {
      string       tag;
      kind_t       k;
      logic [4:0]  a;
      logic [31:0] v;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string t, input kind_t k,
                       input logic [4:0] a, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.k   = k;
      e.a   = a;
      e.v   = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.k)
            K_RD: begin
               bus.rd_addr = e.a;
               #1;
               chk(e.tag, bus.rdata, e.v);
            end
            K_INT: begin
               #1;
               chk(e.tag, {31'b0, bus.int_req}, e.v);
            end
            default: begin
               #1;
               chk(e.tag, bus.epc, e.v);
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we      = 1'b1;
      bus.wr_addr = a;
      bus.wdata   = d;
      tick();
      bus.we      = 1'b0;
   endtask

   initial begin
      bus.rd_addr  = '0;
      bus.wr_addr  = '0;
      bus.wdata    = '0;
      bus.we       = 1'b0;
      bus.pc       = '0;
      bus.bd       = 1'b0;
      bus.exc_code = '0;
      bus.hw_int   = '0;
      bus.eret     = 1'b0;
      tick();
      tick();
      push("rst_sr", K_RD, REG_SR, 32'h0);
      push("rst_int", K_INT, 5'd0, 32'h0);
      push("rst_prid", K_RD, REG_PRID, 32'h0000_2019);
      drain();
      reset = 1'b1;
      tick();

      mtc0(REG_SR, 32'h0000_FC01);
      push("sr_fc01", K_RD, REG_SR, 32'h0000_FC01);
      drain();
      bus.hw_int = 6'b000001;
      push("pre_rst_int", K_INT, 5'd0, 32'h1);
      drain();
      reset = 1'b0;
      push("mid_rst_sr", K_RD, REG_SR, 32'h0);
      push("mid_rst_int", K_INT, 5'd0, 32'h0);
      push("mid_rst_prid", K_RD, REG_PRID, 32'h0000_2019);
      push("mid_rst_epc", K_RD, REG_EPC, 32'h0);
      drain();
      bus.hw_int = '0;
      reset = 1'b1;
      tick();

      mtc0(REG_SR, 32'h0000_0401);
      bus.hw_int = 6'b000001;
      bus.pc     = 32'h0000_3010;
      push("irq0_req", K_INT, 5'd0, 32'h1);
      drain();
      tick();
      bus.hw_int = '0;
      bus.pc     = '0;
      push("irq0_epc", K_RD, REG_EPC, 32'h0000_3010);
      push("irq0_sr", K_RD, REG_SR, 32'h0000_0403);
      push("irq0_cause", K_RD, REG_CAUSE, 32'h0000_0400);
      push("irq0_nonest", K_INT, 5'd0, 32'h0);
      drain();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      push("eret_sr", K_RD, REG_SR, 32'h0000_0401);
      push("eret_cause", K_RD, REG_CAUSE, 32'h0);
      drain();

      mtc0(REG_SR, 32'h0000_0001);
      bus.exc_code = EXC_OV;
      bus.bd       = 1'b1;
      bus.pc       = 32'h0000_3024;
      push("ov_req", K_INT, 5'd0, 32'h1);
      drain();
      tick();
      bus.exc_code = '0;
      bus.bd       = 1'b0;
      push("ov_epc", K_RD, REG_EPC, 32'h0000_3020);
      push("ov_cause", K_RD, REG_CAUSE, 32'h8000_0030);
      push("ov_sr", K_RD, REG_SR, 32'h0000_0003);
      drain();
      bus.eret = 1'b1;
      tick();
      tick();
      bus.eret = 1'b0;
      push("eret_idle_sr", K_RD, REG_SR, 32'h0000_0001);
      drain();

      mtc0(REG_CAUSE, 32'hFFFF_FFFF);
      mtc0(REG_PRID, 32'h0);
      push("cause_ro", K_RD, REG_CAUSE, 32'h8000_0030);
      push("rd_other", K_RD, 5'd7, 32'h0);
      push("prid_ro", K_RD, REG_PRID, 32'h0000_2019);
      push("sr_keep", K_RD, REG_SR, 32'h0000_0001);
      drain();

      mtc0(REG_SR, 32'h0000_0C01);
      bus.hw_int   = 6'b000010;
      bus.exc_code = EXC_ADEL;
      bus.pc       = 32'h0000_3040;
      push("prio_req", K_INT, 5'd0, 32'h1);
      drain();
      tick();
      bus.exc_code = '0;
      bus.hw_int   = 6'b000011;
      push("prio_cause", K_RD, REG_CAUSE, 32'h0000_0800);
      push("prio_sr", K_RD, REG_SR, 32'h0000_0C03);
      push("prio_nonest", K_INT, 5'd0, 32'h0);
      push("prio_epc", K_RD, REG_EPC, 32'h0000_3040);
      drain();
      tick();
      push("hdl_nonest", K_INT, 5'd0, 32'h0);
      push("hdl_ip", K_RD, REG_CAUSE, 32'h0000_0C00);
      drain();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      push("reirq_sr", K_RD, REG_SR, 32'h0000_0C01);
      push("reirq_req", K_INT, 5'd0, 32'h1);
      drain();
      bus.hw_int = '0;
      push("irq_drop", K_INT, 5'd0, 32'h0);
      drain();

      bus.hw_int  = 6'b000001;
      bus.pc      = 32'h0000_3050;
      bus.we      = 1'b1;
      bus.wr_addr = REG_EPC;
      bus.wdata   = 32'h0000_3007;
      push("wdrop_req", K_INT, 5'd0, 32'h1);
      drain();
      tick();
      bus.we     = 1'b0;
      bus.hw_int = '0;
      push("wdrop_epc", K_EPC, 5'd0, 32'h0000_3050);
      push("wdrop_rd", K_RD, REG_EPC, 32'h0000_3050);
      push("wdrop_sr", K_RD, REG_SR, 32'h0000_0C03);
      drain();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      mtc0(REG_EPC, 32'h0000_3007);
      push("epc_align", K_EPC, 5'd0, 32'h0000_3004);
      drain();

      mtc0(REG_SR, 32'h0000_0002);
      push("sw_exl", K_RD, REG_SR, 32'h0000_0002);
      drain();
      bus.eret    = 1'b1;
      bus.we      = 1'b1;
      bus.wr_addr = REG_SR;
      bus.wdata   = 32'h0000_0C03;
      tick();
      bus.eret = 1'b0;
      bus.we   = 1'b0;
      push("eret_mtc0", K_RD, REG_SR, 32'h0000_0C01);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cp0_int.md
Name: cp0_int

Overview:
- Coprocessor-0 exception/interrupt unit for the P7 MIPS pipeline; the receiving end of the IRQ lines driven by the memory-mapped timers and external device.
- Holds SR, Cause, EPC and PRId, answers mfc0/mtc0, and arbitrates hardware interrupts against synchronous exceptions.
- Raises int_req to flush the pipeline and redirect fetch to the handler; eret releases exception level.

Parameters:
PRID, 32'h0000_2019, read-only value returned for CP0 register 15
HW_INT_W, 6, number of hardware interrupt lines (IP/IM width, fixed at 6 for MIPS bits 15:10)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; all state cleared while reset==0
rd_addr  input  5  CP0 register number for mfc0 read
wr_addr  input  5  CP0 register number for mtc0 write
wdata  input  32  mtc0 write data
we  input  1  mtc0 write enable (M stage)
pc  input  32  PC of the instruction in M stage (victim)
bd  input  1  victim instruction is in a branch delay slot
exc_code  input  5  synchronous exception code from M stage, 0 = none
hw_int  input  6  device IRQs: [0] timer0, [1] timer1, [2] external, [5:3] tie 0
eret  input  1  eret in M stage
rdata  output  32  mfc0 read data (combinational)
int_req  output  1  take exception/interrupt this cycle (combinational)
epc  output  32  current EPC register, for eret redirect

Behaviour:
- Registers: SR{IM[15:10], EXL[1], IE[0]}, other bits read 0. Cause{BD[31], IP[15:10], ExcCode[6:2]}, other bits read 0. EPC[31:2], [1:0] read 0.
- Reset (reset==0, async): SR=0, Cause=0, EPC=0 -> int_req=0, epc=0, rdata=0 for regs 12/13/14, PRID for 15.
- rdata: 12->SR, 13->Cause, 14->EPC, 15->PRID, any other number->0. Pure mux, 0-cycle latency, shows register (pre-write) value.
- irq_hit = |(hw_int & SR.IM) & SR.IE & ~SR.EXL, using live hw_int and current SR.
- exc_hit = (exc_code!=0) & ~SR.EXL.
- int_req = irq_hit | exc_hit, same cycle.
- Two-state machine on SR.EXL: NORMAL (EXL=0) -> HANDLER on int_req; HANDLER -> NORMAL on eret or on an mtc0 write clearing EXL. int_req stays 0 while in HANDLER (no nesting).
- On int_req at posedge:
  - EXL<=1.
  - Cause.BD<=bd.
  - EPC<= bd ? pc-4 : pc, with [1:0] forced to 0.
  - Cause.ExcCode<= irq_hit ? 0 : exc_code. The interrupt wins over a simultaneous exception.
- Cause.IP<=hw_int every cycle regardless of EXL/IE (one-cycle sampled copy; it is a status view only).
- mtc0 (we=1): 12 writes IM/EXL/IE only; 14 writes EPC[31:2]. 13, 15 and other numbers are ignored (Cause is software read-only).
- Simultaneous int_req and we: int_req wins and the mtc0 write is dropped. The victim is re-executed after eret.
- Simultaneous eret and we to SR: the mtc0 result applies, then EXL is forced to 0.
- eret with EXL already 0: no effect besides EXL staying 0.
- hw_int deasserting before service: no latch. The interrupt is lost unless the device holds the line, which the timers do until serviced.
- Reset mid-handler: immediate return to NORMAL and all registers 0.

Decomposition:
- cp0_pkg holds:
  - register numbers SR=12, CAUSE=13, EPC=14, PRID=15
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12
  - SR/Cause bit-position constants
- One sub-module, cp0_int_arb: combinational irq_hit/exc_hit/next-ExcCode priority logic, separated out so it can be verified on its own.
- Register file and FSM stay in cp0_int.

Test Plan:
- Reset low mid-run with SR=16'hFC01 -> rdata(12)=0, int_req=0 immediately; rdata(15)=32'h0000_2019.
- mtc0 SR=32'h0000_0401, then hw_int=6'b000001, pc=32'h0000_3010, bd=0 -> int_req=1 that cycle; next cycle EPC=32'h0000_3010, EXL=1, Cause.ExcCode=0, Cause.IP[10]=1.
- EXL=0, IE=1, IM=0, exc_code=12, bd=1, pc=32'h0000_3024 -> int_req=1; EPC=32'h0000_3020, Cause.BD=1, ExcCode=12.
- hw_int[1]=1 with IM[11]=1, IE=1 and exc_code=4 in the same cycle -> ExcCode=0; in HANDLER, raise hw_int[0] -> int_req stays 0; eret -> EXL=0 and int_req=1 next cycle if hw_int[0] is still high.
- we=1, wr_addr=14, wdata=32'h0000_3007 in the same cycle as a pending IRQ -> write dropped, EPC=victim pc; later mtc0 EPC=32'h0000_3007 -> epc=32'h0000_3004.
- mtc0 to reg 13 with 32'hFFFF_FFFF -> Cause unchanged; rd_addr=7 -> rdata=0.
